grn_step_sequencer: RTL and testbench
=====================================

GRN_STEP_SEQUENCER -- requirements
Module: grn_step_sequencer

Interface
REQ-001 SHALL have parameter N_NODES, default 16, number of network nodes driven in parallel.
REQ-002 SHALL have parameter CNT_W, default 16, step-counter width.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a run; ignored unless IDLE.
REQ-006 SHALL have port abort  input  1  terminate the current run; go to IDLE without result.
REQ-007 SHALL have port init_vec  input  N_NODES  initial node states, captured on an accepted start.
REQ-008 SHALL have port max_steps  input  CNT_W  step limit, captured on an accepted start.
REQ-009 SHALL have port state_vec  input  N_NODES  concatenated s1 outputs of all nodes.
REQ-010 SHALL have port reset_nos  output  1  node-reload pulse.
REQ-011 SHALL have port init_state  output  N_NODES  per-node reload value, valid while reset_nos=1.
REQ-012 SHALL have port start_s0  output  1  stage-0 update pulse to all nodes.
REQ-013 SHALL have port start_s1  output  1  stage-1 update pulse to all nodes.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port res_valid / res_ready  output / input  1 each  result handshake.
REQ-016 SHALL have ports res_steps (CNT_W), res_state (N_NODES), res_fixed (1), all outputs  result payload.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, S0, S1, CHECK, DONE.
REQ-018 IDLE: on start=1, SHALL capture init_vec and max_steps, clear step count, and go to LOAD.
REQ-019 LOAD: SHALL drive reset_nos=1 and init_state=captured init_vec for exactly one cycle, load prev_vec=init_vec, then go to S0, or to DONE when max_steps=0.
REQ-020 S0: SHALL drive start_s0=1 for exactly one cycle, then go to S1.
REQ-021 S1: SHALL drive start_s1=1 for exactly one cycle, then go to CHECK.
REQ-022 CHECK: SHALL sample state_vec one cycle after the start_s1 pulse, increment the step count, and set prev_vec=state_vec.
REQ-023 CHECK: if state_vec==prev_vec, SHALL set fixed=1 and go to DONE; else if the incremented count equals max_steps, SHALL set fixed=0 and go to DONE; else SHALL go to S0.
REQ-024 DONE: SHALL hold res_valid=1 with res_steps=count, res_state=last sampled vector (init_vec if no step ran), res_fixed=fixed, all stable until res_ready=1.
REQ-025 DONE: on res_valid&&res_ready, SHALL return to IDLE in the next cycle; a start in that same cycle SHALL be ignored.
REQ-026 reset_nos, start_s0 and start_s1 SHALL be mutually exclusive and SHALL be 0 outside LOAD, S0 and S1 respectively.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE next cycle with no pulse issued that cycle; abort has priority over start and over res_ready.
REQ-028 Full loop SHALL take 3 cycles per step (S0, S1, CHECK); latency from accepted start to res_valid SHALL be 2+3*steps cycles.
REQ-029 Step counter SHALL never wrap; max_steps=2^CNT_W-1 SHALL terminate exactly at that count.

Reset
REQ-030 rst=1 SHALL force IDLE and clear busy, res_valid, reset_nos, start_s0, start_s1, res_steps, res_state, res_fixed, init_state, prev_vec and count to 0, including mid-run.
REQ-031 rst SHALL take priority over abort and start.

Structure
REQ-032 State encoding (grn_seq_state_t) and default widths SHALL live in shared package grn_pkg.
REQ-033 The comparator/step-counter datapath SHALL be one sub-module, grn_step_tracker; FSM remains in the top.

Verification
REQ-034 init_vec=0x00A5, max_steps=4, state_vec constant 0x00A5 -> one S0/S1 pass, res_steps=1, res_fixed=1, res_state=0x00A5.
REQ-035 max_steps=3, state_vec changing every step -> res_steps=3, res_fixed=0, res_valid 11 cycles after start.
REQ-036 max_steps=0 -> reset_nos pulse only, no start_s0/start_s1, res_steps=0, res_state=init_vec.
REQ-037 abort asserted in S1 of step 2 -> IDLE next cycle, res_valid never asserted, busy=0.
REQ-038 res_ready held 0 for 5 cycles in DONE -> payload stable; start pulses meanwhile ignored; handshake then returns to IDLE.
REQ-039 rst asserted in CHECK -> all outputs 0 next cycle; fresh start runs normally.

Source files
------------

// File: rtl/grn_pkg.sv
// Shared types and default sizes for the gene-regulatory-network step sequencer.
package grn_pkg;

  localparam int GRN_N_NODES = 16;
  localparam int GRN_CNT_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    S0,
    S1,
    CHECK,
    DONE
  } grn_seq_state_t;

endpackage

// File: rtl/grn_step_tracker.sv
// Step counter plus previous-state register and fixed-point comparator.
module grn_step_tracker
  import grn_pkg::*;
#(
  parameter int N_NODES = GRN_N_NODES,
  parameter int CNT_W   = GRN_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic               capture,
  input  logic [N_NODES-1:0] init_vec,
  input  logic [N_NODES-1:0] state_vec,
  input  logic [CNT_W-1:0]   max_steps,
  output logic [CNT_W-1:0]   count,
  output logic [N_NODES-1:0] prev_vec,
  output logic               fixed,
  output logic               match,
  output logic               limit
);

  logic [CNT_W-1:0] count_inc;

  // count < max_steps whenever a capture happens, so count_inc cannot wrap
  assign count_inc = count + CNT_W'(1);
  assign match     = (state_vec == prev_vec);
  assign limit     = (count_inc == max_steps);

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      prev_vec <= '0;
      fixed    <= 1'b0;
    end else begin
      if (clear) begin
        count <= '0;
        fixed <= 1'b0;
      end
      if (load) begin
        prev_vec <= init_vec;
      end
      if (capture) begin
        count    <= count_inc;
        prev_vec <= state_vec;
        fixed    <= match;
      end
    end
  end

endmodule

// File: rtl/grn_step_sequencer.sv
// Drives reload / two-stage update pulses to a node array until a fixed point or step limit.
module grn_step_sequencer
  import grn_pkg::*;
#(
  parameter int N_NODES = GRN_N_NODES,
  parameter int CNT_W   = GRN_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [N_NODES-1:0] init_vec,
  input  logic [CNT_W-1:0]   max_steps,
  input  logic [N_NODES-1:0] state_vec,
  output logic               reset_nos,
  output logic [N_NODES-1:0] init_state,
  output logic               start_s0,
  output logic               start_s1,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CNT_W-1:0]   res_steps,
  output logic [N_NODES-1:0] res_state,
  output logic               res_fixed
);

  grn_seq_state_t     state_reg, state_next;
  logic [N_NODES-1:0] init_reg;
  logic [CNT_W-1:0]   max_reg;
  logic               clear, load, capture, match, limit;

  grn_step_tracker #(
    .N_NODES(N_NODES),
    .CNT_W  (CNT_W)
  ) tracker (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .load     (load),
    .capture  (capture),
    .init_vec (init_reg),
    .state_vec(state_vec),
    .max_steps(max_reg),
    .count    (res_steps),
    .prev_vec (res_state),
    .fixed    (res_fixed),
    .match    (match),
    .limit    (limit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      init_reg  <= '0;
      max_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && start) begin
        init_reg <= init_vec;
        max_reg  <= max_steps;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    reset_nos  = 1'b0;
    start_s0   = 1'b0;
    start_s1   = 1'b0;
    clear      = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    // abort suppresses every pulse and datapath update in its cycle
    if (abort && state_reg != IDLE) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            clear      = 1'b1;
            state_next = LOAD;
          end
        end
        LOAD: begin
          reset_nos  = 1'b1;
          load       = 1'b1;
          state_next = (max_reg == '0) ? DONE : S0;
        end
        S0: begin
          start_s0   = 1'b1;
          state_next = S1;
        end
        S1: begin
          start_s1   = 1'b1;
          state_next = CHECK;
        end
        CHECK: begin
          capture    = 1'b1;
          state_next = (match || limit) ? DONE : S0;
        end
        DONE: begin
          if (res_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign init_state = reset_nos ? init_reg : '0;
  assign busy       = (state_reg != IDLE);
  assign res_valid  = (state_reg == DONE);

endmodule

// File: tb/tb_grn_step_sequencer.sv
// Scoreboard bench: a behavioural node network feeds state_vec; a run-level model predicts each result.
module tb_grn_step_sequencer;

  localparam int NN = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort, res_ready;
  logic [NN-1:0] init_vec, state_vec, init_state, res_state;
  logic [CW-1:0] max_steps, res_steps;
  logic          reset_nos, start_s0, start_s1, busy, res_valid, res_fixed;

  always #5 clk = ~clk;

  grn_step_sequencer #(.N_NODES(NN), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .init_vec  (init_vec),
    .max_steps (max_steps),
    .state_vec (state_vec),
    .reset_nos (reset_nos),
    .init_state(init_state),
    .start_s0  (start_s0),
    .start_s1  (start_s1),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_steps (res_steps),
    .res_state (res_state),
    .res_fixed (res_fixed)
  );

  typedef struct {
    int            steps;
    logic [NN-1:0] state;
    logic          fixed;
    int            lat;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          cur;
  int            compared = 0;
  int            mismatched = 0;
  int            cyc = 0;
  int            cur_mode;
  logic [NN-1:0] mask, net;

  assign state_vec = net;

  function automatic logic [NN-1:0] step_fn(int mode, logic [NN-1:0] v, logic [NN-1:0] m);
    case (mode)
      0:       return v;
      1:       return v + NN'(1);
      2:       return v >> 1;
      default: return v & m;
    endcase
  endfunction

  // Behavioural node array: reload on reset_nos, advance one update on start_s1
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) net <= '0;
    else if (reset_nos) net <= init_state;
    else if (start_s1) net <= step_fn(cur_mode, net, mask);
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(logic [NN-1:0] iv, int ms, int mode, logic [NN-1:0] m);
    exp_t          e;
    logic [NN-1:0] v, nv;
    e.steps = 0; e.fixed = 1'b0; e.state = iv;
    v = iv;
    while (e.steps < ms) begin
      nv = step_fn(mode, v, m);
      e.steps++;
      e.state = nv;
      if (nv == v) begin
        e.fixed = 1'b1;
        break;
      end
      v = nv;
    end
    e.lat = 2 + 3 * e.steps;
    return e;
  endfunction

  // Monitor
  int start_cyc = 0, n_load = 0, n_s0 = 0, n_s1 = 0;
  bit in_done = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_done = 0; n_load = 0; n_s0 = 0; n_s1 = 0;
    end else begin
      check("pulse_legal",
            32'((32'(reset_nos) + 32'(start_s0) + 32'(start_s1) <= 1) &&
                (busy || !(reset_nos || start_s0 || start_s1))), 32'd1);
      n_load += 32'(reset_nos);
      n_s0   += 32'(start_s0);
      n_s1   += 32'(start_s1);
      if (res_valid) begin
        if (!in_done) begin
          in_done = 1;
          if (exp_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL unexpected_result: res_valid=1 with steps=%0d, required no result", res_steps);
            cur.steps = 32'(res_steps); cur.state = res_state; cur.fixed = res_fixed;
          end else begin
            cur = exp_q.pop_front();
            check("latency", 32'(cyc - start_cyc), 32'(cur.lat));
            check("load_pulses", 32'(n_load), 32'd1);
            check("s0_pulses", 32'(n_s0), 32'(cur.steps));
            check("s1_pulses", 32'(n_s1), 32'(cur.steps));
            $display("result: steps=%0d state=0x%04h fixed=%0d lat=%0d", res_steps, res_state,
                     res_fixed, cyc - start_cyc);
          end
        end
        check("res_steps", 32'(res_steps), 32'(cur.steps));
        check("res_state", 32'(res_state), 32'(cur.state));
        check("res_fixed", 32'(res_fixed), 32'(cur.fixed));
        if (res_ready && !abort) in_done = 0;
      end else begin
        in_done = 0;
      end
      if (start && !busy) begin
        start_cyc = cyc; n_load = 0; n_s0 = 0; n_s1 = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(logic [NN-1:0] iv, int ms, int mode, bit push);
    if (push) exp_q.push_back(model(iv, ms, mode, mask));
    cur_mode  = mode;
    init_vec  = iv;
    max_steps = CW'(ms);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    init_vec  = NN'($urandom);
    max_steps = CW'($urandom);
  endtask

  task automatic finish_run(int hold, bit noise);
    int t = 0;
    while (!res_valid && t < 1000) begin
      tick();
      t++;
    end
    if (!res_valid) check("result_timeout", 32'(res_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    res_ready = 1'b1;
    start     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    res_ready = 1'b0;
    start     = 1'b0;
    check("idle_after_hs", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_pulses"}, 32'({reset_nos, start_s0, start_s1}), 32'd0);
    check({tag, "_steps"}, 32'(res_steps), 32'd0);
    check({tag, "_state"}, 32'(res_state), 32'd0);
    check({tag, "_fixed"}, 32'(res_fixed), 32'd0);
    check({tag, "_init_state"}, 32'(init_state), 32'd0);
  endtask

  initial begin
    int seen, t, mode, ms;
    rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    init_vec = '0; max_steps = '0; cur_mode = 0; mask = '0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    launch(16'h00A5, 4, 0, 1'b1);                 // immediate fixed point
    finish_run(0, 1'b0);
    launch(NN'($urandom), 3, 1, 1'b1);            // limit after 3 changing steps
    finish_run(0, 1'b0);
    launch(NN'($urandom), 0, 1, 1'b1);            // zero-step run
    finish_run(0, 1'b0);

    // abort in S1 of step 2
    launch(NN'($urandom), 10, 1, 1'b0);
    seen = 0; t = 0;
    while (seen < 2 && t < 50) begin
      if (start_s0) seen++;
      if (seen < 2) tick();
      t++;
    end
    check("abort_reach_s0", 32'(seen), 32'd2);
    tick();
    abort = 1'b1;
    #1;
    check("abort_no_s1", 32'(start_s1), 32'd0);
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(res_valid), 32'd0);
    repeat (10) tick();

    launch(NN'($urandom), 5, 2, 1'b1);            // stall in DONE with start noise
    finish_run(5, 1'b1);

    // rst while in CHECK
    launch(NN'($urandom), 10, 1, 1'b0);
    t = 0;
    while (!start_s1 && t < 50) begin
      tick();
      t++;
    end
    check("rst_reach_s1", 32'(start_s1), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check_all_zero("midrun_rst");
    rst = 1'b0;
    tick();
    launch(NN'($urandom), 2, 1, 1'b1);
    finish_run(0, 1'b0);

    launch(NN'($urandom), 255, 1, 1'b1);          // counter ceiling
    finish_run(1, 1'b0);

    for (int r = 0; r < 30; r++) begin
      mode = int'($urandom_range(0, 3));
      mask = NN'($urandom);
      ms   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 8));
      launch(NN'($urandom), ms, mode, 1'b1);
      finish_run(int'($urandom_range(0, 3)), 1'b1);
    end

    repeat (3) tick();
    if (exp_q.size() != 0) check("results_outstanding", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
